// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: direction codes, traceback states, width helper.
`default_nettype none

package nw_pkg;

  localparam logic [1:0] DIR_DIAG = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_LEFT = 2'b10;
  localparam logic [1:0] DIR_RSV  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } tb_state_t;

  function automatic int addr_width(input int n);
    return $clog2((n + 1) * (n + 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks the direction matrix from (N,N) to (0,0),
// emitting one alignment operation per step.
`default_nettype none

module nw_traceback
  import nw_pkg::*;
#(
  parameter int N      = 8,
  parameter int ADDR_W = addr_width(N),
  parameter int IDX_W  = $clog2(N + 1),
  parameter int CNT_W  = $clog2(2 * N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_traceB,
  input  logic [1:0]        dir_data,
  output logic [ADDR_W-1:0] dir_addr,
  output logic              dir_re,
  output logic              out_valid,
  output logic [1:0]        out_op,
  output logic [IDX_W-1:0]  out_i,
  output logic [IDX_W-1:0]  out_j,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              err,
  output logic              ending
);

  localparam logic [IDX_W-1:0]  N_IDX     = IDX_W'(N);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((N + 1) * (N + 1) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(N + 1);
  localparam logic [ADDR_W-1:0] DIAG_STEP = ADDR_W'(N + 2);

  tb_state_t          state;
  logic [IDX_W-1:0]   i;
  logic [IDX_W-1:0]   j;
  logic [ADDR_W-1:0]  addr;
  logic [IDX_W-1:0]   step_i;
  logic [IDX_W-1:0]   step_j;
  logic [ADDR_W-1:0]  step_addr;

  assign dir_addr = addr;

  // Next cell for the operation held in out_op (reserved code never reaches out_op).
  always_comb begin
    step_i    = i;
    step_j    = j;
    step_addr = addr;
    case (out_op)
      DIR_UP: begin
        step_i    = i - IDX_W'(1);
        step_addr = addr - ROW_STEP;
      end
      DIR_LEFT: begin
        step_j    = j - IDX_W'(1);
        step_addr = addr - ADDR_W'(1);
      end
      default: begin
        step_i    = i - IDX_W'(1);
        step_j    = j - IDX_W'(1);
        step_addr = addr - DIAG_STEP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      i         <= N_IDX;
      j         <= N_IDX;
      addr      <= LAST_ADDR;
      dir_re    <= 1'b0;
      out_valid <= 1'b0;
      out_op    <= DIR_DIAG;
      out_i     <= '0;
      out_j     <= '0;
      out_cnt   <= '0;
      err       <= 1'b0;
      ending    <= 1'b0;
    end else if (state != ST_IDLE && !en_traceB) begin
      // Abort: err and out_cnt stay visible until the next start.
      state     <= ST_IDLE;
      dir_re    <= 1'b0;
      out_valid <= 1'b0;
      ending    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_traceB) begin
            state   <= ST_ISSUE;
            i       <= N_IDX;
            j       <= N_IDX;
            addr    <= LAST_ADDR;
            out_cnt <= '0;
            err     <= 1'b0;
            dir_re  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          dir_re <= 1'b0;
          if (i == '0 && j == '0) begin
            state  <= ST_DONE;
            ending <= 1'b1;
          end else if (i == '0 || j == '0) begin
            state     <= ST_STEP;
            out_valid <= 1'b1;
            out_op    <= (i == '0) ? DIR_LEFT : DIR_UP;
            out_i     <= i;
            out_j     <= j;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          state     <= ST_STEP;
          out_valid <= 1'b1;
          out_op    <= (dir_data == DIR_RSV) ? DIR_DIAG : dir_data;
          err       <= err | (dir_data == DIR_RSV);
          out_i     <= i;
          out_j     <= j;
        end
        ST_STEP: begin
          out_valid <= 1'b0;
          out_cnt   <= out_cnt + CNT_W'(1);
          i         <= step_i;
          j         <= step_j;
          addr      <= step_addr;
          // Reaching the origin goes straight to DONE so ending follows the last pulse.
          if (step_i == '0 && step_j == '0) begin
            state  <= ST_DONE;
            ending <= 1'b1;
          end else begin
            state  <= ST_ISSUE;
            dir_re <= (step_i != '0) && (step_j != '0);
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nw_traceback.sv
// Self-checking bench for nw_traceback (N=4) against a behavioural traceback model.
`default_nettype none

module tb_nw_traceback;

  localparam int NN = 4;
  localparam int AW = $clog2((NN + 1) * (NN + 1));
  localparam int IW = $clog2(NN + 1);
  localparam int CW = $clog2(2 * NN + 1);
  localparam int CELLS = (NN + 1) * (NN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en_traceB;
  logic [1:0]    dir_data;
  logic [AW-1:0] dir_addr;
  logic          dir_re;
  logic          out_valid;
  logic [1:0]    out_op;
  logic [IW-1:0] out_i;
  logic [IW-1:0] out_j;
  logic [CW-1:0] out_cnt;
  logic          err;
  logic          ending;

  nw_traceback #(.N(NN)) dut (
    .clk(clk), .rst(rst), .en_traceB(en_traceB), .dir_data(dir_data),
    .dir_addr(dir_addr), .dir_re(dir_re), .out_valid(out_valid), .out_op(out_op),
    .out_i(out_i), .out_j(out_j), .out_cnt(out_cnt), .err(err), .ending(ending)
  );

  always #5 clk = ~clk;

  logic [1:0] mem [0:CELLS-1];

  always @(posedge clk) begin
    if (dir_re) dir_data <= mem[dir_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference walk derived straight from the matrix contents.
  int m_op[$], m_i[$], m_j[$], m_rd[$], m_addr[$];
  bit m_err;

  task automatic build_model();
    int ci, cj, a, c, op;
    m_op.delete(); m_i.delete(); m_j.delete(); m_rd.delete(); m_addr.delete();
    m_err = 0;
    ci = NN; cj = NN;
    while (ci > 0 || cj > 0) begin
      if (ci == 0) begin
        op = 2; m_rd.push_back(0);
      end else if (cj == 0) begin
        op = 1; m_rd.push_back(0);
      end else begin
        a = ci * (NN + 1) + cj;
        c = int'(mem[a]);
        m_addr.push_back(a);
        m_rd.push_back(1);
        if (c == 3) begin m_err = 1; op = 0; end
        else op = c;
      end
      m_op.push_back(op); m_i.push_back(ci); m_j.push_back(cj);
      if (op == 0) begin ci--; cj--; end
      else if (op == 1) ci--;
      else cj--;
    end
  endtask

  int o_op[$], o_i[$], o_j[$], o_cnt[$], o_cyc[$], r_addr[$], r_cyc[$];
  int end_cyc, overlap;
  bit got_end;

  task automatic run_walk();
    int cyc;
    o_op.delete(); o_i.delete(); o_j.delete(); o_cnt.delete(); o_cyc.delete();
    r_addr.delete(); r_cyc.delete();
    got_end = 0; overlap = 0; end_cyc = 0; cyc = 0;
    en_traceB = 1'b1;
    while (!got_end && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (dir_re) begin r_addr.push_back(int'(dir_addr)); r_cyc.push_back(cyc); end
      if (out_valid) begin
        o_op.push_back(int'(out_op)); o_i.push_back(int'(out_i)); o_j.push_back(int'(out_j));
        o_cnt.push_back(int'(out_cnt)); o_cyc.push_back(cyc);
      end
      if (out_valid && ending) overlap++;
      if (ending) begin got_end = 1; end_cyc = cyc; end
    end
  endtask

  task automatic compare_walk(input string nm);
    int n, rdi, prev;
    build_model();
    check({nm, " reached_end"}, got_end, 1);
    check({nm, " pulses"}, o_op.size(), m_op.size());
    check({nm, " reads"}, r_addr.size(), m_addr.size());
    n = (o_op.size() < m_op.size()) ? o_op.size() : m_op.size();
    rdi = 0;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s op%0d", nm, k), o_op[k], m_op[k]);
      check($sformatf("%s i%0d", nm, k), o_i[k], m_i[k]);
      check($sformatf("%s j%0d", nm, k), o_j[k], m_j[k]);
      check($sformatf("%s cnt%0d", nm, k), o_cnt[k], k);
      prev = (k == 0) ? 0 : o_cyc[k-1];
      check($sformatf("%s gap%0d", nm, k), o_cyc[k] - prev, (m_rd[k] != 0) ? 3 : 2);
      if (m_rd[k] != 0 && rdi < r_addr.size() && rdi < m_addr.size()) begin
        check($sformatf("%s addr%0d", nm, k), r_addr[rdi], m_addr[rdi]);
        check($sformatf("%s rdlat%0d", nm, k), o_cyc[k] - r_cyc[rdi], 2);
        rdi++;
      end
    end
    if (got_end && n > 0) check({nm, " end_lag"}, end_cyc - o_cyc[n-1], 1);
    check({nm, " final_cnt"}, out_cnt, m_op.size());
    check({nm, " err"}, err, m_err);
    check({nm, " overlap"}, overlap, 0);
  endtask

  task automatic stop_walk(input string nm);
    en_traceB = 1'b0;
    @(negedge clk);
    check({nm, " ending_clr"}, ending, 0);
  endtask

  task automatic fill(input int code);
    for (int a = 0; a < CELLS; a++) mem[a] = 2'(code);
  endtask

  initial begin
    int cnt, viol;
    rst = 1'b0; en_traceB = 1'b0; dir_data = 2'b00;
    fill(0);
    repeat (3) @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst dir_re", dir_re, 0);
    check("rst ending", ending, 0);
    check("rst err", err, 0);
    check("rst out_cnt", out_cnt, 0);
    check("rst dir_addr", dir_addr, CELLS - 1);
    check("rst out_ij", {out_i, out_j, out_op}, 0);
    rst = 1'b1;
    @(negedge clk);

    fill(0); run_walk(); compare_walk("diag");
    stop_walk("diag");

    fill(1); run_walk(); compare_walk("up");
    stop_walk("up");

    fill(0); mem[CELLS-1] = 2'b11; run_walk(); compare_walk("rsv");
    repeat (3) @(negedge clk);
    check("rsv err_sticky", err, 1);

    // Hold in DONE, then abort from DONE keeping err.
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!ending || dir_re || out_valid) viol++;
    end
    check("done_hold viol", viol, 0);
    en_traceB = 1'b0;
    @(negedge clk);
    check("done_exit ending", ending, 0);
    check("done_exit err_held", err, 1);

    // Abort while a read is in flight (WAIT of the second cell).
    fill(0);
    en_traceB = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 2; c++) begin
      @(negedge clk);
      if (dir_re) cnt++;
    end
    check("abort reached_issue", cnt, 2);
    @(negedge clk);
    en_traceB = 1'b0;
    @(negedge clk);
    check("abort out_valid", out_valid, 0);
    check("abort ending", ending, 0);
    check("abort cnt_held", out_cnt, 1);
    check("abort err_cleared", err, 0);
    viol = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid || dir_re) viol++;
    end
    check("abort quiet", viol, 0);
    run_walk(); compare_walk("restart");
    stop_walk("restart");

    // Asynchronous reset mid-walk.
    fill(1);
    en_traceB = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 2; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("arst two_pulses", cnt, 2);
    #2 rst = 1'b0;
    #1;
    check("arst outs", {out_valid, dir_re, ending, err, out_op, out_i, out_j, out_cnt}, 0);
    check("arst dir_addr", dir_addr, CELLS - 1);
    @(negedge clk);
    rst = 1'b1;
    run_walk(); compare_walk("arst");
    stop_walk("arst");

    for (int w = 0; w < 25; w++) begin
      for (int a = 0; a < CELLS; a++)
        mem[a] = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_walk();
      compare_walk($sformatf("rnd%0d", w));
      stop_walk($sformatf("rnd%0d", w));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
